regfile_mp_sb: RTL and testbench

//   Parametrised multi-read-port register file for the pipelined core, with one write port,

---
 rtl/regfile_mp_sb.sv | 96 +++++++++
 tb/tb_regfile_mp_sb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with one write port, optional same-cycle
// write forwarding, hardwired zero register and a busy-bit scoreboard that
// decode uses to detect operands still owned by an in-flight producer.
module regfile_mp_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD        = 2,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            RegWrite,
    input  logic [ADDRESS_WIDTH-1:0]        rg_wrt_dest,
    input  logic [DATA_WIDTH-1:0]           rg_wrt_data,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rs_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    input  logic                            issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]        issue_dest,
    output logic [NUM_RD-1:0]               rs_busy,
    output logic                            any_busy
);

    // Storage spans the full address space so any address indexes it without
    // width adaptation; entries at or above NUM_REGS are never written and
    // are masked on read, so they collapse to constants.
    localparam int   DEPTH   = 2**ADDRESS_WIDTH;
    localparam logic BYP_EN  = (BYPASS != 0);
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0]    regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic                     wr_legal;
    logic                     iss_legal;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     rd_hit;

    // An address is architecturally real if it is implemented and not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        logic [31:0] a_ext;
        a_ext = 32'(a);
        return (a_ext < 32'(NUM_REGS)) && !(ZERO_EN && (a == '0));
    endfunction

    assign wr_legal  = RegWrite && addr_ok(rg_wrt_dest);
    assign iss_legal = issue_valid && addr_ok(issue_dest);

    // Register array: writeback port, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else if (wr_legal) begin
            regs[rg_wrt_dest] <= rg_wrt_data;
        end
    end

    // Scoreboard: writeback clears, issue sets; the later assignment makes
    // a same-register issue win over the completing write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_legal) begin
                busy[rg_wrt_dest] <= 1'b0;
            end
            if (iss_legal) begin
                busy[issue_dest] <= 1'b1;
            end
        end
    end

    // Read ports: combinational data and hazard flags, with forwarding of a
    // same-cycle legal write that also hides the busy bit it is about to clear.
    always_comb begin
        rd_data = '0;
        rs_busy = '0;
        rd_addr = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = rs_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            rd_hit  = BYP_EN && wr_legal && (rg_wrt_dest == rd_addr);
            if (!rst && addr_ok(rd_addr)) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_hit ? rg_wrt_data : regs[rd_addr];
                rs_busy[i] = !rd_hit && busy[rd_addr];
            end
        end
    end

    // Summary hazard flag straight from the busy bits.
    assign any_busy = !rst && (|busy);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: three instances (default, no forwarding, 16 regs
// with 4 read ports) share write/issue stimulus; a per-cycle compare process
// checks every output against an architectural model of the register file.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic        issue_valid;
    logic [4:0]  issue_dest;

    logic [9:0]   rs_a;       // two ports, shared by u0 and u1
    logic [19:0]  rs_c;       // four ports for u2
    logic [63:0]  rd_a0, rd_a1;
    logic [127:0] rd_c;
    logic [1:0]   bz_a0, bz_a1;
    logic [3:0]   bz_c;
    logic         ab_a0, ab_a1, ab_c;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp_sb #(.BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest),
        .rg_wrt_data(rg_wrt_data), .rs_addr(rs_a), .rd_data(rd_a0),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .rs_busy(bz_a0), .any_busy(ab_a0));

    regfile_mp_sb #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest),
        .rg_wrt_data(rg_wrt_data), .rs_addr(rs_a), .rd_data(rd_a1),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .rs_busy(bz_a1), .any_busy(ab_a1));

    regfile_mp_sb #(.NUM_REGS(16), .NUM_RD(4)) u2 (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest),
        .rg_wrt_data(rg_wrt_data), .rs_addr(rs_c), .rd_data(rd_c),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .rs_busy(bz_c), .any_busy(ab_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state: cfg 0 = 32 registers, cfg 1 = 16 registers.
    logic [31:0] m_regs [2][32];
    logic        m_busy [2][32];

    function automatic int nregs(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic bit legal(input int a, input int c);
        return (a != 0) && (a < nregs(c));
    endfunction

    function automatic bit fwd(input int a, input int c, input bit byp);
        return byp && RegWrite && legal(int'(rg_wrt_dest), c) && (int'(rg_wrt_dest) == a);
    endfunction

    function automatic logic [31:0] exp_data(input int a, input int c, input bit byp);
        if (rst || !legal(a, c)) return 32'h0;
        if (fwd(a, c, byp)) return rg_wrt_data;
        return m_regs[c][a];
    endfunction

    function automatic logic exp_busy(input int a, input int c, input bit byp);
        if (rst || !legal(a, c)) return 1'b0;
        if (fwd(a, c, byp)) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic logic exp_any(input int c);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 32; k++) r = r | m_busy[c][k];
        return r && !rst;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model update: a legal write stores data and retires the producer, then
    // a legal issue marks a new producer (so it wins on a collision).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 32; k++) begin
                    m_regs[c][k] = 32'h0;
                    m_busy[c][k] = 1'b0;
                end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (RegWrite && legal(int'(rg_wrt_dest), c)) begin
                    m_regs[c][rg_wrt_dest] = rg_wrt_data;
                    m_busy[c][rg_wrt_dest] = 1'b0;
                end
                if (issue_valid && legal(int'(issue_dest), c))
                    m_busy[c][issue_dest] = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            chk("u0_rd",   rd_a0[p*32 +: 32], exp_data(int'(rs_a[p*5 +: 5]), 0, 1'b1));
            chk("u0_busy", 32'(bz_a0[p]),     32'(exp_busy(int'(rs_a[p*5 +: 5]), 0, 1'b1)));
            chk("u1_rd",   rd_a1[p*32 +: 32], exp_data(int'(rs_a[p*5 +: 5]), 0, 1'b0));
            chk("u1_busy", 32'(bz_a1[p]),     32'(exp_busy(int'(rs_a[p*5 +: 5]), 0, 1'b0)));
        end
        for (int p = 0; p < 4; p++) begin
            chk("u2_rd",   rd_c[p*32 +: 32], exp_data(int'(rs_c[p*5 +: 5]), 1, 1'b1));
            chk("u2_busy", 32'(bz_c[p]),     32'(exp_busy(int'(rs_c[p*5 +: 5]), 1, 1'b1)));
        end
        chk("u0_any", 32'(ab_a0), 32'(exp_any(0)));
        chk("u1_any", 32'(ab_a1), 32'(exp_any(0)));
        chk("u2_any", 32'(ab_c),  32'(exp_any(1)));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite    = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_random();
        RegWrite    = 1'($urandom_range(1));
        rg_wrt_dest = 5'($urandom_range(31));
        rg_wrt_data = $urandom;
        issue_valid = 1'($urandom_range(1));
        issue_dest  = 5'($urandom_range(31));
        rs_a        = 10'($urandom);
        rs_c        = 20'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        drive_random();

        // Reset with live inputs: everything reads zero.
        for (int n = 0; n < 4; n++) begin
            drive_random();
            mid();
            chk("rst_rd0",  rd_a0[31:0], 32'h0);
            chk("rst_any",  32'(ab_a0), 32'h0);
            chk("rst_busy", 32'(bz_c), 32'h0);
            step();
        end
        idle();
        rs_a = '0;
        rs_c = '0;
        rst  = 1'b0;
        step();

        for (int a = 0; a < 32; a++) begin
            rs_a = {5'(31 - a), 5'(a)};
            rs_c = {4{5'(a)}};
            mid();
            chk("post_rst_rd", rd_a0[31:0], 32'h0);
            step();
        end

        // Write r4, read it back next cycle on port 1.
        RegWrite = 1'b1; rg_wrt_dest = 5'd4; rg_wrt_data = 32'h12345678;
        rs_a = {5'd4, 5'd1};
        step();
        idle();
        mid();
        chk("wr_r4_p1", rd_a0[63:32], 32'h12345678);
        chk("wr_r1_p0", rd_a0[31:0],  32'h0);
        step();

        // Forwarding vs. no forwarding for r7.
        RegWrite = 1'b1; rg_wrt_dest = 5'd7; rg_wrt_data = 32'hDEADBEEF;
        rs_a = {5'd4, 5'd7};
        mid();
        chk("byp_same_cycle",   rd_a0[31:0], 32'hDEADBEEF);
        chk("nobyp_same_cycle", rd_a1[31:0], 32'h0);
        step();
        idle();
        mid();
        chk("nobyp_next_cycle", rd_a1[31:0], 32'hDEADBEEF);
        step();

        // Zero register ignores writes and issues.
        RegWrite = 1'b1; rg_wrt_dest = 5'd0; rg_wrt_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_dest = 5'd0;
        rs_a = {5'd0, 5'd0};
        mid();
        chk("zero_byp", rd_a0[31:0], 32'h0);
        step();
        idle();
        mid();
        chk("zero_rd",   rd_a0[31:0], 32'h0);
        chk("zero_busy", 32'(bz_a0[0]), 32'h0);
        chk("zero_any",  32'(ab_a0), 32'h0);
        step();

        // Scoreboard on r9: issue, retire, then issue+retire collision.
        issue_valid = 1'b1; issue_dest = 5'd9;
        rs_a = {5'd4, 5'd9};
        mid();
        chk("sb_not_yet", 32'(bz_a0[0]), 32'h0);
        step();
        idle();
        mid();
        chk("sb_busy9", 32'(bz_a0[0]), 32'h1);
        chk("sb_any",   32'(ab_a0), 32'h1);
        step();
        RegWrite = 1'b1; rg_wrt_dest = 5'd9; rg_wrt_data = 32'h00000099;
        mid();
        chk("sb_byp_hide",   32'(bz_a0[0]), 32'h0);
        chk("sb_nobyp_show", 32'(bz_a1[0]), 32'h1);
        step();
        idle();
        mid();
        chk("sb_cleared", 32'(bz_a0[0]), 32'h0);
        chk("sb_any_clr", 32'(ab_a0), 32'h0);
        step();
        RegWrite = 1'b1; issue_valid = 1'b1; issue_dest = 5'd9; rg_wrt_data = 32'h0000AAAA;
        step();
        idle();
        mid();
        chk("sb_set_wins", 32'(bz_a0[0]), 32'h1);
        step();
        RegWrite = 1'b1;
        step();
        idle();

        // 16-register, 4-port instance: r20 is out of range there.
        RegWrite = 1'b1; rg_wrt_dest = 5'd20; rg_wrt_data = 32'h0000ABCD;
        issue_valid = 1'b1; issue_dest = 5'd20;
        rs_c = {4{5'd20}};
        rs_a = {5'd20, 5'd20};
        mid();
        chk("p16_r20_byp", rd_c[31:0], 32'h0);
        step();
        idle();
        mid();
        chk("p16_r20_rd",  rd_c[95:64], 32'h0);
        chk("p16_any",     32'(ab_c), 32'h0);
        chk("p32_r20_rd",  rd_a0[31:0], 32'h0000ABCD);
        step();
        RegWrite = 1'b1; rg_wrt_dest = 5'd3; rg_wrt_data = 32'h00003333;
        rs_c = {4{5'd3}};
        step();
        idle();
        mid();
        for (int p = 0; p < 4; p++) chk("p16_r3_port", rd_c[p*32 +: 32], 32'h00003333);
        step();

        // Random traffic, checked every cycle by the compare process.
        for (int n = 0; n < 60; n++) begin
            drive_random();
            step();
        end

        // Reset in the middle of activity discards that cycle's write/issue.
        RegWrite = 1'b1; rg_wrt_dest = 5'd4; rg_wrt_data = 32'h55555555;
        issue_valid = 1'b1; issue_dest = 5'd5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        rs_a = {5'd5, 5'd4};
        mid();
        chk("midrst_r4",  rd_a0[31:0], 32'h0);
        chk("midrst_b5",  32'(bz_a0[1]), 32'h0);
        chk("midrst_any", 32'(ab_a0), 32'h0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
